// File: rtl/cluster_drv_pkg.sv
// Shared types and sizing helpers for the cluster vector driver.
// Holds the FSM state encoding and the stream word-count function.
package cluster_drv_pkg;

  localparam int DEF_IN_W   = 1894;
  localparam int DEF_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2
  } drv_state_t;

  // Number of stream words needed to carry an in_w-bit vector.
  function automatic int nwords(input int in_w, input int word_w);
    return (in_w + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/sat_cnt32.sv
// 32-bit event counter that saturates at all-ones; clr has priority over inc.
module sat_cnt32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] q
);

  logic [31:0] q_d;

  always_comb begin
    q_d = q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q != 32'hFFFF_FFFF)) begin
      q_d = q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/cluster_vector_driver.sv
// Assembles a wide cluster input vector from a word stream, waits for the
// cluster to settle, then checks its outputs against the frame's expected bits.
module cluster_vector_driver
  import cluster_drv_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int OUT_W  = 1,
  parameter int WORD_W = DEF_WORD_W,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic [IN_W-1:0]   vec_o,
  input  logic [OUT_W-1:0]  dut_o,
  input  logic              clr,
  output logic              cmp_valid,
  output logic              cmp_match,
  output logic [31:0]       test_cnt,
  output logic [31:0]       err_cnt,
  output logic              frame_err,
  output drv_state_t        dbg_state
);

  localparam int NW     = nwords(IN_W, WORD_W);
  localparam int WIDX_W = $clog2(NW + 1);
  localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WIDX_W-1:0] NW_IDX = WIDX_W'(NW);

  drv_state_t        state_q, state_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [SCNT_W-1:0] settle_q, settle_d;
  logic [OUT_W-1:0]  exp_bits_q;

  logic accept, at_exp, good_end, bad_frame, word_we;

  // Handshake: a word transfers on a rising edge where s_valid && s_ready;
  // s_ready is high only in LOAD and the source may idle s_valid at any time.
  assign s_ready   = (state_q == ST_LOAD);
  assign accept    = s_valid && s_ready;
  assign at_exp    = (widx_q == NW_IDX);
  assign good_end  = accept && at_exp && s_last;
  assign bad_frame = accept && (at_exp != s_last);
  assign word_we   = accept && !at_exp;

  assign cmp_valid = (state_q == ST_CHECK);
  assign cmp_match = cmp_valid && (dut_o == exp_bits_q);
  assign dbg_state = state_q;

  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    settle_d = settle_q;
    case (state_q)
      ST_LOAD: begin
        if (bad_frame) begin
          widx_d = '0;
        end else if (good_end) begin
          state_d  = ST_SETTLE;
          settle_d = SCNT_W'(SETTLE - 1);
        end else if (accept) begin
          widx_d = widx_q + WIDX_W'(1);
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q - SCNT_W'(1);
        end
      end
      ST_CHECK: begin
        state_d = ST_LOAD;
        widx_d  = '0;
      end
      default: begin
        state_d = ST_LOAD;
        widx_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      widx_q     <= '0;
      settle_q   <= '0;
      exp_bits_q <= '0;
      frame_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      settle_q <= settle_d;
      if (good_end) begin
        exp_bits_q <= s_data[OUT_W-1:0];
      end
      if (clr) begin
        frame_err <= 1'b0;
      end else if (bad_frame) begin
        frame_err <= 1'b1;
      end
    end
  end

  // One register slice per stream word; the final word is truncated to IN_W.
  for (genvar w = 0; w < NW; w++) begin : g_word
    localparam int LO   = w * WORD_W;
    localparam int BITS = ((IN_W - LO) < WORD_W) ? (IN_W - LO) : WORD_W;

    logic [BITS-1:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_q <= '0;
      end else if (word_we && (widx_q == WIDX_W'(w))) begin
        word_q <= s_data[BITS-1:0];
      end
    end

    assign vec_o[LO +: BITS] = word_q;
  end

  sat_cnt32 u_test_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (cmp_valid),
    .q     (test_cnt)
  );

  sat_cnt32 u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (cmp_valid && !cmp_match),
    .q     (err_cnt)
  );

endmodule
